// File: rtl/time_set_ctrl.sv
// Time-set controller: captures the live time, lets the user step and bump
// hour/min/sec fields, then pulses load on exit. Also drives field blink.
//
// state    | meaning
// ---------+----------------------------------------------------
// S_IDLE   | not editing; capture live time when timeset_run rises
// S_HOUR   | editing hour field
// S_MIN    | editing minute field
// S_SEC    | editing second field
// S_COMMIT | one-cycle load pulse, then back to S_IDLE
module time_set_ctrl #(
    parameter int BLINK_DIV = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       timeset_run,
    input  logic       sw_sel,
    input  logic       sw_inc,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [4:0] set_hour,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       load,
    output logic [1:0] field,
    output logic       blink
);

    localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOUR,
        S_MIN,
        S_SEC,
        S_COMMIT
    } state_t;

    state_t        state;
    state_t        sel_next;
    logic          sel_q;
    logic          inc_q;
    logic          sel_edge;
    logic          inc_edge;
    logic [CW-1:0] blink_cnt;
    logic [4:0]    hour_inc;
    logic [5:0]    min_inc;
    logic [5:0]    sec_inc;

    assign sel_edge = sw_sel & ~sel_q;
    assign inc_edge = sw_inc & ~inc_q;

    // Out-of-range captured values fold back to zero on the first bump.
    assign hour_inc = (set_hour >= 5'd23) ? 5'd0 : set_hour + 5'd1;
    assign min_inc  = (set_min  >= 6'd59) ? 6'd0 : set_min  + 6'd1;
    assign sec_inc  = (set_sec  >= 6'd59) ? 6'd0 : set_sec  + 6'd1;

    always_comb begin
        sel_next = S_HOUR;
        case (state)
            S_HOUR:  sel_next = S_MIN;
            S_MIN:   sel_next = S_SEC;
            default: sel_next = S_HOUR;
        endcase
    end

    function automatic logic [1:0] field_code(input state_t s);
        case (s)
            S_HOUR:  return 2'd1;
            S_MIN:   return 2'd2;
            S_SEC:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sel_q     <= 1'b0;
            inc_q     <= 1'b0;
            set_hour  <= '0;
            set_min   <= '0;
            set_sec   <= '0;
            load      <= 1'b0;
            field     <= 2'd0;
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else begin
            sel_q <= sw_sel;
            inc_q <= sw_inc;
            load  <= 1'b0;
            case (state)
                S_IDLE: begin
                    field     <= 2'd0;
                    blink     <= 1'b1;
                    blink_cnt <= '0;
                    if (timeset_run) begin
                        set_hour <= cur_hour;
                        set_min  <= cur_min;
                        set_sec  <= cur_sec;
                        state    <= S_HOUR;
                        field    <= 2'd1;
                    end
                end
                S_HOUR, S_MIN, S_SEC: begin
                    if (!timeset_run) begin
                        state     <= S_COMMIT;
                        load      <= 1'b1;
                        field     <= 2'd0;
                        blink     <= 1'b1;
                        blink_cnt <= '0;
                    end else begin
                        if (inc_edge) begin
                            case (state)
                                S_HOUR:  set_hour <= hour_inc;
                                S_MIN:   set_min  <= min_inc;
                                S_SEC:   set_sec  <= sec_inc;
                                default: ;
                            endcase
                        end
                        if (sel_edge) begin
                            state <= sel_next;
                            field <= field_code(sel_next);
                        end
                        if (inc_edge || sel_edge) begin
                            blink     <= 1'b1;
                            blink_cnt <= '0;
                        end else if (blink_cnt == CNT_LAST) begin
                            blink     <= ~blink;
                            blink_cnt <= '0;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    state     <= S_IDLE;
                    field     <= 2'd0;
                    blink     <= 1'b1;
                    blink_cnt <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus random switch/run traffic
// checked against an event-level model of the edit session.
module tb_time_set_ctrl;

    localparam int BD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       timeset_run = 1'b0;
    logic       sw_sel = 1'b0;
    logic       sw_inc = 1'b0;
    logic [4:0] cur_hour = '0;
    logic [5:0] cur_min = '0;
    logic [5:0] cur_sec = '0;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       load;
    logic [1:0] field;
    logic       blink;

    int total = 0;
    int bad = 0;

    // reference model state
    int m_h, m_m, m_s, m_fld, blink_n;
    bit editing, committing, m_load, p_sel, p_inc;

    time_set_ctrl #(.BLINK_DIV(BD)) dut (
        .clk(clk), .rst_n(rst_n), .timeset_run(timeset_run),
        .sw_sel(sw_sel), .sw_inc(sw_inc),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .load(load), .field(field), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_h = 0; m_m = 0; m_s = 0; m_fld = 1; blink_n = 0;
        editing = 0; committing = 0; m_load = 0; p_sel = 0; p_inc = 0;
    endtask

    function automatic bit exp_blink();
        return editing ? (((blink_n / BD) % 2) == 0) : 1'b1;
    endfunction

    function automatic logic [1:0] exp_field();
        return editing ? 2'(m_fld) : 2'd0;
    endfunction

    task automatic model_step(input bit run, input bit sel, input bit inc);
        bit se, ie;
        se = sel && !p_sel;
        ie = inc && !p_inc;
        p_sel = sel;
        p_inc = inc;
        m_load = 0;
        if (committing) begin
            committing = 0;
        end else if (!editing) begin
            if (run) begin
                m_h = cur_hour; m_m = cur_min; m_s = cur_sec;
                editing = 1; m_fld = 1; blink_n = 0;
            end
        end else if (!run) begin
            editing = 0; committing = 1; m_load = 1;
        end else begin
            if (ie) begin
                if (m_fld == 1) m_h = (m_h < 23) ? m_h + 1 : 0;
                if (m_fld == 2) m_m = (m_m < 59) ? m_m + 1 : 0;
                if (m_fld == 3) m_s = (m_s < 59) ? m_s + 1 : 0;
            end
            if (se) m_fld = (m_fld % 3) + 1;
            if (ie || se) blink_n = 0;
            else blink_n++;
        end
    endtask

    task automatic tick(input bit run, input bit sel, input bit inc);
        timeset_run = run;
        sw_sel = sel;
        sw_inc = inc;
        model_step(run, sel, inc);
        @(posedge clk);
        #1;
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        cur_hour = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sw_sel = 1'b1; sw_inc = 1'b1; timeset_run = 1'b0;
        set_cur(7, 8, 9);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({set_hour, set_min, set_sec} !== 17'd0) begin
            bad++; $display("FAIL reset_set got=%0d:%0d:%0d exp=0:0:0", set_hour, set_min, set_sec);
        end
        total++;
        if ({load, field, blink} !== 4'b0001) begin
            bad++; $display("FAIL reset_ctl got load=%b field=%0d blink=%b exp 0/0/1", load, field, blink);
        end
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 1);
            total++;
            if ({set_hour, set_min, set_sec, load, field, blink} !== {17'd0, 4'b0001}) begin
                bad++; $display("FAIL post_reset_idle cyc=%0d got=%0d:%0d:%0d l=%b f=%0d b=%b", i,
                                set_hour, set_min, set_sec, load, field, blink);
            end
        end
    endtask

    task automatic test_basic();
        set_cur(12, 34, 56);
        tick(1, 0, 0);
        total++;
        if (field !== 2'd1 || {set_hour, set_min, set_sec} !== {5'd12, 6'd34, 6'd56}) begin
            bad++; $display("FAIL entry got f=%0d %0d:%0d:%0d exp f=1 12:34:56", field, set_hour, set_min, set_sec);
        end
        tick(1, 0, 1); tick(1, 0, 1); tick(1, 0, 0); tick(1, 0, 1); tick(1, 0, 0);
        total++;
        if (set_hour !== 5'd14) begin
            bad++; $display("FAIL inc_hour got=%0d exp=14", set_hour);
        end
        tick(0, 0, 0);
        total++;
        if (load !== 1'b1 || {set_hour, set_min, set_sec} !== {5'd14, 6'd34, 6'd56}) begin
            bad++; $display("FAIL commit got load=%b %0d:%0d:%0d exp 1 14:34:56", load, set_hour, set_min, set_sec);
        end
        tick(0, 0, 0);
        total++;
        if (load !== 1'b0 || field !== 2'd0) begin
            bad++; $display("FAIL commit_end got load=%b field=%0d exp 0/0", load, field);
        end
        tick(0, 0, 0);
    endtask

    task automatic test_wrap();
        set_cur(23, 59, 59);
        tick(1, 0, 0);
        tick(1, 0, 1);
        tick(1, 1, 0);
        tick(1, 0, 1);
        tick(1, 1, 0);
        tick(1, 0, 1);
        total++;
        if ({set_hour, set_min, set_sec} !== 17'd0 || field !== 2'd3) begin
            bad++; $display("FAIL wrap got %0d:%0d:%0d f=%0d exp 0:0:0 f=3", set_hour, set_min, set_sec, field);
        end
        tick(1, 1, 0);
        total++;
        if (field !== 2'd1) begin
            bad++; $display("FAIL field_wrap got=%0d exp=1", field);
        end
        tick(0, 0, 0); tick(0, 0, 0);
    endtask

    task automatic test_same_cycle();
        set_cur(5, 10, 20);
        tick(1, 0, 0);
        tick(1, 1, 0);
        tick(1, 0, 0);
        tick(1, 1, 1);
        total++;
        if (set_min !== 6'd11 || field !== 2'd3) begin
            bad++; $display("FAIL inc_sel_same got min=%0d f=%0d exp 11/3", set_min, field);
        end
        tick(1, 0, 0);
        tick(0, 0, 1);
        total++;
        if (load !== 1'b1 || {set_hour, set_min, set_sec} !== {5'd5, 6'd11, 6'd20}) begin
            bad++; $display("FAIL inc_on_exit got load=%b %0d:%0d:%0d exp 1 5:11:20", load, set_hour, set_min, set_sec);
        end
        tick(0, 0, 0);
        total++;
        if (load !== 1'b0) begin
            bad++; $display("FAIL single_load got=%b exp=0", load);
        end
    endtask

    task automatic test_min_session();
        set_cur(3, 4, 5);
        tick(1, 0, 0);
        tick(0, 0, 0);
        total++;
        if (load !== 1'b1 || {set_hour, set_min, set_sec} !== {5'd3, 6'd4, 6'd5}) begin
            bad++; $display("FAIL min_session got load=%b %0d:%0d:%0d exp 1 3:4:5", load, set_hour, set_min, set_sec);
        end
        tick(0, 0, 0);
    endtask

    task automatic test_blink();
        bit exp_b;
        set_cur(1, 2, 3);
        tick(1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            exp_b = ((i / 4) % 2) == 0;
            total++;
            if (blink !== exp_b) begin
                bad++; $display("FAIL blink_pattern i=%0d got=%b exp=%b", i, blink, exp_b);
            end
            tick(1, 0, 0);
        end
        // now 16 cycles after entry: back in high phase; move into low phase
        repeat (5) tick(1, 0, 0);
        total++;
        if (blink !== 1'b0) begin
            bad++; $display("FAIL blink_low got=%b exp=0", blink);
        end
        tick(1, 0, 1);
        for (int i = 0; i < 8; i++) begin
            exp_b = ((i / 4) % 2) == 0;
            total++;
            if (blink !== exp_b) begin
                bad++; $display("FAIL blink_restart i=%0d got=%b exp=%b", i, blink, exp_b);
            end
            tick(1, 0, 0);
        end
        tick(0, 0, 0); tick(0, 0, 0);
    endtask

    task automatic test_reset_mid();
        set_cur(9, 9, 9);
        tick(1, 0, 0);
        tick(1, 1, 0); tick(1, 0, 0); tick(1, 1, 0);
        tick(1, 0, 1); tick(1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({set_hour, set_min, set_sec, load, field, blink} !== {17'd0, 4'b0001}) begin
            bad++; $display("FAIL reset_mid got %0d:%0d:%0d l=%b f=%0d b=%b", set_hour, set_min, set_sec,
                            load, field, blink);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            total++;
            if (load !== 1'b0 || field !== 2'd0) begin
                bad++; $display("FAIL reset_hold got load=%b field=%0d exp 0/0", load, field);
            end
        end
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0);
            total++;
            if (load !== 1'b0 || {set_hour, set_min, set_sec} !== 17'd0) begin
                bad++; $display("FAIL no_load_after_abort cyc=%0d load=%b", i, load);
            end
        end
    endtask

    task automatic test_random();
        bit run, sel, inc;
        logic [20:0] exp_v;
        run = 0;
        for (int i = 0; i < 600; i++) begin
            set_cur($urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
            if ($urandom_range(0, 14) == 0) run = !run;
            else if (!run && $urandom_range(0, 3) == 0) run = 1;
            sel = ($urandom_range(0, 3) == 0);
            inc = ($urandom_range(0, 2) == 0);
            tick(run, sel, inc);
            exp_v = {5'(m_h), 6'(m_m), 6'(m_s), m_load, exp_field(), exp_blink()};
            total++;
            if ({set_hour, set_min, set_sec, load, field, blink} !== exp_v) begin
                bad++;
                $display("FAIL random cyc=%0d got=%0d:%0d:%0d l=%b f=%0d b=%b exp=%0d:%0d:%0d l=%b f=%0d b=%b",
                         i, set_hour, set_min, set_sec, load, field, blink,
                         m_h, m_m, m_s, m_load, exp_field(), exp_blink());
            end
        end
        tick(0, 0, 0); tick(0, 0, 0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_wrap();
        test_same_cycle();
        test_min_session();
        test_blink();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Time-set controller for the digital clock. It runs while the mode selector's TIMESET_RUN output is high. On entry it captures the live time into an edit buffer, then lets the user pick a field (hour/min/sec) and increment it. Exiting time-set mode issues a one-cycle LOAD that writes the edited time into the timekeeping counters. It also generates the blink enable used by the display for the selected field.

## Interface
- BLINK_DIV, default 500: clock cycles per blink half-period; legal range ≥ 2.
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- TIMESET_RUN  in  1  time-set mode active (level), from the mode selector.
- SW_SEL  in  1  field-select switch. Already synchronized/debounced. Acts on its rising edge.
- SW_INC  in  1  increment switch. Already synchronized/debounced. Acts on its rising edge.
- CUR_HOUR  in  5  live hour, 0–23.
- CUR_MIN  in  6  live minute, 0–59.
- CUR_SEC  in  6  live second, 0–59.
- SET_HOUR  out  5  edit-buffer hour.
- SET_MIN  out  6  edit-buffer minute.
- SET_SEC  out  6  edit-buffer second.
- LOAD  out  1  one-cycle pulse; timekeeper loads SET_* on it.
- FIELD  out  2  0 = none, 1 = hour, 2 = min, 3 = sec.
- BLINK  out  1  1 = selected field visible, 0 = blanked.

## Operation
- Edge detect:
  - sel_q and inc_q register SW_SEL and SW_INC; both reset to 0.
  - sel_edge = SW_SEL & ~sel_q; inc_edge = SW_INC & ~inc_q.
  - Edges are evaluated only in the HOUR, MIN and SEC states and ignored in all other states.
- States: IDLE, HOUR, MIN, SEC, COMMIT. FIELD encodes the state: IDLE/COMMIT → 0, HOUR → 1, MIN → 2, SEC → 3.
- IDLE:
  - If TIMESET_RUN = 1: copy CUR_* into SET_*, then go to HOUR.
  - Otherwise stay in IDLE; SET_* hold their value.
- HOUR/MIN/SEC, in priority order:
  - If TIMESET_RUN = 0: go to COMMIT. A same-cycle inc_edge or sel_edge is discarded.
  - If inc_edge: increment the selected field. Hour wraps 23→0; min and sec wrap 59→0. Any value ≥ max (out-of-range captured value) becomes 0.
  - If sel_edge: advance HOUR→MIN→SEC→HOUR.
  - inc_edge and sel_edge in the same cycle: the increment applies to the current field first, then the field advances.
- COMMIT:
  - LOAD = 1 for exactly this one cycle; SET_* stable.
  - Next state is always IDLE. If TIMESET_RUN is high again, re-entry (with a fresh capture) happens from IDLE.
- Blink:
  - A counter runs 0..BLINK_DIV-1 in HOUR/MIN/SEC and toggles BLINK when it wraps.
  - On entry to HOUR, on any field change and on any increment: counter clears and BLINK = 1.
  - In IDLE/COMMIT: counter = 0 and BLINK = 1.
- Reset (any time, including mid-edit):
  - State → IDLE; SET_* = 0; LOAD = 0; FIELD = 0; BLINK = 1; counter = 0; sel_q = inc_q = 0.
  - No LOAD is issued for an edit aborted by reset.

## Timing
- All outputs are registered; none depend combinationally on inputs.
- Entry: TIMESET_RUN sampled high at edge k in IDLE → after edge k, FIELD = 1 and SET_* = CUR_* as sampled at edge k.
- Switch action: SW_INC sampled 1 at edge k with inc_q = 0 → SET_* updated after edge k. SW_SEL behaves the same for FIELD.
- Holding a switch high gives exactly one action.
- Exit: TIMESET_RUN sampled low at edge k in an edit state → LOAD = 1 during the cycle after edge k. LOAD = 0 and FIELD = 0 after edge k+1.
- Minimum edit session is 1 cycle (TIMESET_RUN high for one sample) → capture, COMMIT, LOAD. This rewrites the current time unchanged.
- BLINK period in an edit state with no activity is 2×BLINK_DIV cycles: high for BLINK_DIV cycles, then low for BLINK_DIV cycles.

## Test plan
- Reset with switches high, then release, TIMESET_RUN = 0 → SET_* = 0, LOAD = 0, FIELD = 0, BLINK = 1. No action on the first post-reset edges.
- CUR = 12:34:56, raise TIMESET_RUN → next cycle FIELD = 1, SET = 12:34:56. Two SW_INC pulses → SET_HOUR = 14. Drop TIMESET_RUN → single LOAD pulse with SET = 14:34:56.
- Capture 23:59:59; INC on hour, SEL, INC on min, SEL, INC on sec → 00:00:00. One more SEL → FIELD wraps to 1.
- SW_INC and SW_SEL rise in the same cycle in MIN with min = 10 → min = 11, FIELD = 3. SW_INC rising in the same cycle TIMESET_RUN falls → no increment, LOAD = 1 next cycle.
- BLINK_DIV = 4, idle in HOUR → BLINK pattern 1111 0000 repeating. SW_INC mid-low-phase → BLINK = 1 immediately after that edge and the counter restarts.
- Assert RST in SEC with edits pending → immediate IDLE, SET_* = 0, no LOAD at any point.
